button_event_decoder: RTL and testbench
=======================================

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter LONG_PRESS_CYCLES, default 1000, hold length in clk cycles that qualifies as a long press (>=2).
REQ-002 Parameter DBL_GAP_CYCLES, default 250, maximum released gap in clk cycles between clicks of a double click (>=2).
REQ-003 Parameter CNT_BITS, default 20, width of the internal hold/gap counter; must hold max(LONG_PRESS_CYCLES, DBL_GAP_CYCLES).
REQ-004 Port clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port reset  input  1  reset, synchronous, active-high.
REQ-006 Port btn_level  input  1  debounced, clk-synchronous button level; 1 = pressed.
REQ-007 Port press_pulse  output  1  one-cycle pulse on each press edge.
REQ-008 Port release_pulse  output  1  one-cycle pulse on each release edge.
REQ-009 Port short_press  output  1  one-cycle pulse for a completed press shorter than LONG_PRESS_CYCLES.
REQ-010 Port long_press  output  1  one-cycle pulse when a hold reaches LONG_PRESS_CYCLES.
REQ-011 Port double_click  output  1  one-cycle pulse for a second press within the gap window; constant 0 when the feature is compiled out.
REQ-012 Port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 All outputs SHALL be registered; each event pulse SHALL be high for exactly one cycle, in the cycle after the clk edge at which its condition is sampled.
REQ-014 Edge detect SHALL compare btn_level against a registered copy btn_prev; rise = level & ~prev, fall = ~level & prev.
REQ-015 FSM states SHALL be IDLE, PRESSED, HOLD, WAIT_SECOND (WAIT_SECOND only with the macro).
REQ-016 IDLE: on rise -> press_pulse, counter cleared to 0, go PRESSED.
REQ-017 PRESSED: each edge with level high increments counter; at the edge where counter == LONG_PRESS_CYCLES-1 and level high -> long_press, go HOLD (long_press appears LONG_PRESS_CYCLES edges after the press edge).
REQ-018 PRESSED: on fall -> release_pulse; without macro also short_press and go IDLE; with macro clear counter, go WAIT_SECOND, no short_press yet.
REQ-019 Fall and threshold at the same edge: fall wins; short-press path taken, no long_press.
REQ-020 HOLD: no events except release_pulse on fall, then IDLE; counter frozen.
REQ-021 WAIT_SECOND: each edge with level low increments counter; at counter == DBL_GAP_CYCLES-1 -> short_press, go IDLE.
REQ-022 WAIT_SECOND: on rise -> press_pulse and double_click in the same cycle, go HOLD; rise at the expiry edge wins over expiry (double_click, no short_press).
REQ-023 Counter SHALL never wrap; it stops at the active threshold.
REQ-024 At most one of short_press, long_press, double_click SHALL be high in any cycle.

Reset
REQ-025 While reset high: FSM -> IDLE, counter -> 0, all outputs -> 0, btn_prev loads btn_level.
REQ-026 A button held through reset deassertion SHALL produce no press_pulse until released and pressed again; its release SHALL produce release_pulse only.
REQ-027 Reset mid-operation SHALL discard any pending short/long/double event with no pulse emitted.

Configuration
REQ-028 Macro BUTTON_DOUBLE_CLICK_EN: when defined, WAIT_SECOND and double-click detection compiled in (REQ-018 delayed short_press, REQ-021, REQ-022).
REQ-029 When undefined, WAIT_SECOND logic and DBL_GAP_CYCLES usage are absent, short_press is emitted on release, double_click tied to 0.

Verification (bench parameters LONG_PRESS_CYCLES=8, DBL_GAP_CYCLES=4)
REQ-030 Level high 3 cycles then low, macro off -> press_pulse at +1, release_pulse and short_press together one cycle after fall, nothing else.
REQ-031 Level high 20 cycles -> long_press exactly 8 edges after press edge, then only release_pulse on fall; no short_press.
REQ-032 Macro on: press 2 cycles, release 2 cycles, press again -> double_click with second press_pulse, no short_press; release later -> release_pulse only.
REQ-033 Macro on: press 2 cycles, release held low -> short_press 4 edges after fall edge; rise exactly on 4th edge -> double_click instead.
REQ-034 Level high during reset, reset dropped, held 10 cycles, released -> no press_pulse, no long_press, single release_pulse.
REQ-035 Reset asserted in PRESSED after 5 held cycles -> all outputs 0, busy 0, no event pulse after reset.

Source files
------------

// File: rtl/button_event_decoder_if.sv
// rtl/button_event_decoder_if.sv - button level input and decoded event outputs
interface button_event_decoder_if;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic double_click;
  logic busy;

  // Drives the button level and observes the events.
  modport master (
    output btn_level,
    input  press_pulse,
    input  release_pulse,
    input  short_press,
    input  long_press,
    input  double_click,
    input  busy
  );

  // The decoder itself.
  modport slave (
    input  btn_level,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press,
    output double_click,
    output busy
  );
endinterface

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - press/release/short/long/double-click decoder (optional macro BUTTON_DOUBLE_CLICK_EN)
module button_event_decoder #(
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int DBL_GAP_CYCLES    = 250,
  parameter int CNT_BITS          = 20
) (
  input logic                   clk,
  input logic                   reset,
  button_event_decoder_if.slave bus
);

  localparam logic [CNT_BITS-1:0] LONG_LAST = CNT_BITS'(LONG_PRESS_CYCLES - 1);
`ifdef BUTTON_DOUBLE_CLICK_EN
  localparam logic [CNT_BITS-1:0] GAP_LAST  = CNT_BITS'(DBL_GAP_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HOLD
`ifdef BUTTON_DOUBLE_CLICK_EN
    , ST_WAIT_SECOND
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                btn_prev_q;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                short_q, short_d;
  logic                long_q, long_d;
  logic                busy_q, busy_d;
`ifdef BUTTON_DOUBLE_CLICK_EN
  logic                dbl_q, dbl_d;
`endif

  logic rise;
  logic fall;

  assign rise = bus.btn_level & ~btn_prev_q;
  assign fall = ~bus.btn_level & btn_prev_q;

  // Next-state, counter and event decode; the counter only advances while
  // below the active threshold, so it can never wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
    dbl_d     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_PRESSED;
        end else if (fall) begin
          // Release of a button that was already held when reset ended.
          release_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        // Checking fall first makes a release win over the long threshold.
        if (fall) begin
          release_d = 1'b1;
`ifdef BUTTON_DOUBLE_CLICK_EN
          cnt_d   = '0;
          state_d = ST_WAIT_SECOND;
`else
          short_d = 1'b1;
          state_d = ST_IDLE;
`endif
        end else if (bus.btn_level) begin
          if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
`ifdef BUTTON_DOUBLE_CLICK_EN
      ST_WAIT_SECOND: begin
        // A second press on the expiry edge still counts as a double click.
        if (rise) begin
          press_d = 1'b1;
          dbl_d   = 1'b1;
          state_d = ST_HOLD;
        end else if (!bus.btn_level) begin
          if (cnt_q == GAP_LAST) begin
            short_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered outputs; btn_prev tracks the level even in
  // reset so a button held across reset release is not seen as a new press.
  always_ff @(posedge clk) begin
    btn_prev_q <= bus.btn_level;
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
      dbl_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      busy_q    <= busy_d;
`ifdef BUTTON_DOUBLE_CLICK_EN
      dbl_q     <= dbl_d;
`endif
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.short_press   = short_q;
  assign bus.long_press    = long_q;
  assign bus.busy          = busy_q;
`ifdef BUTTON_DOUBLE_CLICK_EN
  assign bus.double_click  = dbl_q;
`else
  assign bus.double_click  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder
module tb_button_event_decoder;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_DBL   = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  button_event_decoder_if bus_if();

  button_event_decoder #(
    .LONG_PRESS_CYCLES(8),
    .DBL_GAP_CYCLES   (4),
    .CNT_BITS         (20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every visible event must match the head of the expected queue,
  // and expected events whose cycle has passed are reported as missed.
  always @(negedge clk) begin
    logic [4:0] ev;
    exp_t       e;
    ev = {bus_if.press_pulse, bus_if.release_pulse, bus_if.short_press,
          bus_if.long_press, bus_if.double_click};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event: got none, expected %b at cycle %0d", exp_q[0].ev, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (ev != 5'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %b at cycle %0d, expected nothing", ev, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.ev !== ev) begin
          errors++;
          $display("FAIL event: got %b at cycle %0d, expected %b at cycle %0d", ev, cyc, e.ev, e.cyc);
        end
      end
    end
  end

  task automatic expect_ev(input int at, input logic [4:0] ev);
    exp_t e;
    e.cyc = at;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] all_outputs();
    return {bus_if.press_pulse, bus_if.release_pulse, bus_if.short_press,
            bus_if.long_press, bus_if.double_click, bus_if.busy};
  endfunction

  initial begin
    int c;
    bus_if.btn_level = 1'b0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    check("reset_outputs", 32'(all_outputs()), 32'h0);
    idle(2);

    // Short press: high for 3 edges.
    c = cyc;
    bus_if.btn_level = 1'b1;
    expect_ev(c + 1, EV_PRESS);
    idle(2);
    check("busy_pressed", 32'(bus_if.busy), 32'h1);
    idle(1);
    bus_if.btn_level = 1'b0;
    expect_ev(c + 4, EV_REL | EV_SHORT);
    idle(6);
    check("busy_idle", 32'(bus_if.busy), 32'h0);

    // Long hold of 20 cycles.
    c = cyc;
    bus_if.btn_level = 1'b1;
    expect_ev(c + 1, EV_PRESS);
    expect_ev(c + 9, EV_LONG);
    idle(20);
    bus_if.btn_level = 1'b0;
    expect_ev(c + 21, EV_REL);
    idle(6);

    // Fall on the threshold edge: release wins, no long press.
    c = cyc;
    bus_if.btn_level = 1'b1;
    expect_ev(c + 1, EV_PRESS);
    idle(8);
    bus_if.btn_level = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
    expect_ev(c + 9, EV_REL);
    expect_ev(c + 13, EV_SHORT);
`else
    expect_ev(c + 9, EV_REL | EV_SHORT);
`endif
    idle(8);

    // One edge longer: long press fires, then release only.
    c = cyc;
    bus_if.btn_level = 1'b1;
    expect_ev(c + 1, EV_PRESS);
    expect_ev(c + 9, EV_LONG);
    idle(9);
    bus_if.btn_level = 1'b0;
    expect_ev(c + 10, EV_REL);
    idle(6);

    // Two presses separated by a 2-cycle gap.
    c = cyc;
    bus_if.btn_level = 1'b1;
    expect_ev(c + 1, EV_PRESS);
    idle(2);
    bus_if.btn_level = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
    expect_ev(c + 3, EV_REL);
`else
    expect_ev(c + 3, EV_REL | EV_SHORT);
`endif
    idle(2);
    bus_if.btn_level = 1'b1;
`ifdef BUTTON_DOUBLE_CLICK_EN
    expect_ev(c + 5, EV_PRESS | EV_DBL);
`else
    expect_ev(c + 5, EV_PRESS);
`endif
    idle(5);
    bus_if.btn_level = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
    expect_ev(c + 10, EV_REL);
`else
    expect_ev(c + 10, EV_REL | EV_SHORT);
`endif
    idle(8);

    // Single click left to expire.
    c = cyc;
    bus_if.btn_level = 1'b1;
    expect_ev(c + 1, EV_PRESS);
    idle(2);
    bus_if.btn_level = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
    expect_ev(c + 3, EV_REL);
    expect_ev(c + 7, EV_SHORT);
    idle(3);
    check("busy_wait_second", 32'(bus_if.busy), 32'h1);
    idle(7);
`else
    expect_ev(c + 3, EV_REL | EV_SHORT);
    idle(10);
`endif

    // Second press exactly on the expiry edge.
    c = cyc;
    bus_if.btn_level = 1'b1;
    expect_ev(c + 1, EV_PRESS);
    idle(2);
    bus_if.btn_level = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
    expect_ev(c + 3, EV_REL);
`else
    expect_ev(c + 3, EV_REL | EV_SHORT);
`endif
    idle(4);
    bus_if.btn_level = 1'b1;
`ifdef BUTTON_DOUBLE_CLICK_EN
    expect_ev(c + 7, EV_PRESS | EV_DBL);
`else
    expect_ev(c + 7, EV_PRESS);
`endif
    idle(3);
    bus_if.btn_level = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
    expect_ev(c + 10, EV_REL);
`else
    expect_ev(c + 10, EV_REL | EV_SHORT);
`endif
    idle(8);

    // Button held through reset: only the release is reported.
    c = cyc;
    reset = 1'b1;
    bus_if.btn_level = 1'b1;
    idle(3);
    reset = 1'b0;
    check("held_reset_outputs", 32'(all_outputs()), 32'h0);
    idle(10);
    bus_if.btn_level = 1'b0;
    expect_ev(c + 14, EV_REL);
    idle(12);
    check("held_reset_busy", 32'(bus_if.busy), 32'h0);

    // Reset while PRESSED discards the pending event.
    c = cyc;
    bus_if.btn_level = 1'b1;
    expect_ev(c + 1, EV_PRESS);
    idle(5);
    check("busy_before_reset", 32'(bus_if.busy), 32'h1);
    reset = 1'b1;
    idle(1);
    check("mid_reset_outputs", 32'(all_outputs()), 32'h0);
    bus_if.btn_level = 1'b0;
    idle(1);
    reset = 1'b0;
    idle(15);
    check("after_reset_outputs", 32'(all_outputs()), 32'h0);

    idle(2);
    check("pending_expected", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
